// File: rtl/mux16_select_pkg.sv
// Shared constants for the 16-to-1 registered selector and its 4-to-1 building block.
package mux16_select_pkg;
    localparam int unsigned NUM_LANES = 16;
    localparam int unsigned SEL_W     = 4;
    localparam int unsigned LVL_FANIN = 4;
endpackage

// File: rtl/mux16_select_mux4_lane.sv
// Combinational 4-to-1 lane selector. It is the building block for both levels of the selector tree.
module mux4_lane
    import mux16_select_pkg::*;
#(
    parameter int unsigned DATA_W = 1
) (
    input  logic [LVL_FANIN*DATA_W-1:0] lanes_i,
    input  logic [1:0]                  sel_i,
    output logic [DATA_W-1:0]           out_o
);

    always_comb begin
        out_o = '0;
        case (sel_i)
            2'd0:    out_o = lanes_i[0*DATA_W +: DATA_W];
            2'd1:    out_o = lanes_i[1*DATA_W +: DATA_W];
            2'd2:    out_o = lanes_i[2*DATA_W +: DATA_W];
            default: out_o = lanes_i[3*DATA_W +: DATA_W];
        endcase
    end

endmodule

// File: rtl/mux16_select.sv
// Registered 16-to-1 selector. It is built as a two-level tree of 4-to-1 stages.
// PIPE=1 adds a register between the two levels.
module mux16_select
    import mux16_select_pkg::*;
#(
    parameter int unsigned DATA_W = 1,
    parameter int unsigned PIPE   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [NUM_LANES*DATA_W-1:0] in,
    input  logic [SEL_W-1:0]            sel,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out
);

    localparam int unsigned GRP_W = LVL_FANIN * DATA_W;

    logic [LVL_FANIN*DATA_W-1:0] t_flat;
    logic [LVL_FANIN*DATA_W-1:0] stg_t;
    logic [1:0]                  stg_sel;
    logic                        stg_vld;
    logic [DATA_W-1:0]           lvl2;

    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;

    genvar g;
    generate
        for (g = 0; g < LVL_FANIN; g++) begin : g_l1
            mux4_lane #(.DATA_W(DATA_W)) u_l1 (
                .lanes_i (in[g*GRP_W +: GRP_W]),
                .sel_i   (sel[1:0]),
                .out_o   (t_flat[g*DATA_W +: DATA_W])
            );
        end

        if (PIPE != 0) begin : g_pipe
            logic [LVL_FANIN*DATA_W-1:0] t_q;
            logic [1:0]                  sel_hi_q;
            logic                        vld_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    t_q      <= '0;
                    sel_hi_q <= '0;
                    vld_q    <= 1'b0;
                end else begin
                    t_q      <= t_flat;
                    sel_hi_q <= sel[3:2];
                    vld_q    <= in_valid;
                end
            end

            assign stg_t   = t_q;
            assign stg_sel = sel_hi_q;
            assign stg_vld = vld_q;
        end else begin : g_flat
            assign stg_t   = t_flat;
            assign stg_sel = sel[3:2];
            assign stg_vld = in_valid;
        end
    endgenerate

    mux4_lane #(.DATA_W(DATA_W)) u_l2 (
        .lanes_i (stg_t),
        .sel_i   (stg_sel),
        .out_o   (lvl2)
    );

    // When no valid selection is in flight, the output holds its last value.
    always_comb begin
        out_d       = out_q;
        out_valid_d = stg_vld;
        if (stg_vld) begin
            out_d = lvl2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux16_select.sv
// Directed bench for mux16_select. Four instances run side by side from shared select and valid inputs:
// 1-bit lanes at PIPE 0 and 1, and 8-bit lanes at PIPE 0 and 1.
module tb_mux16_select;

    typedef struct {
        logic [15:0] in1;
        logic [3:0]  sel;
        logic        vld;
        logic        e1;
        logic [7:0]  e8;
    } vec_t;

    typedef struct {
        logic       e1;
        logic [7:0] e8;
        logic       ev;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid;
    logic [3:0]   sel;
    logic [15:0]  in1;
    logic [127:0] in8;

    logic       ov_p0, o_p0, ov_p1, o_p1;
    logic       ov_w0, ov_w1;
    logic [7:0] o_w0, o_w1;

    int tests = 0;
    int fails = 0;

    exp_t a1, a2;
    bit   a1_ok = 1'b0;
    bit   a2_ok = 1'b0;

    mux16_select #(.DATA_W(1), .PIPE(0)) u_p0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in1), .sel(sel),
        .out_valid(ov_p0), .out(o_p0));
    mux16_select #(.DATA_W(1), .PIPE(1)) u_p1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in1), .sel(sel),
        .out_valid(ov_p1), .out(o_p1));
    mux16_select #(.DATA_W(8), .PIPE(0)) u_w0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in8), .sel(sel),
        .out_valid(ov_w0), .out(o_w0));
    mux16_select #(.DATA_W(8), .PIPE(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in8), .sel(sel),
        .out_valid(ov_w1), .out(o_w1));

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " p0 out"},   {7'b0, o_p0},  8'h00);
        check({tag, " p0 valid"}, {7'b0, ov_p0}, 8'h00);
        check({tag, " p1 out"},   {7'b0, o_p1},  8'h00);
        check({tag, " p1 valid"}, {7'b0, ov_p1}, 8'h00);
        check({tag, " w0 out"},   o_w0,          8'h00);
        check({tag, " w0 valid"}, {7'b0, ov_w0}, 8'h00);
        check({tag, " w1 out"},   o_w1,          8'h00);
        check({tag, " w1 valid"}, {7'b0, ov_w1}, 8'h00);
    endtask

    // At each falling edge, the PIPE=0 outputs are checked against the vector applied one cycle earlier.
    // The PIPE=1 outputs are checked against the vector applied two cycles earlier.
    task automatic step(input logic [15:0] v_in, input logic [3:0] v_sel, input logic v_vld,
                        input logic v_e1, input logic [7:0] v_e8, input bit chk);
        @(negedge clk);
        if (a1_ok) begin
            check("p0 out",   {7'b0, o_p0},  {7'b0, a1.e1});
            check("p0 valid", {7'b0, ov_p0}, {7'b0, a1.ev});
            check("w0 out",   o_w0,          a1.e8);
            check("w0 valid", {7'b0, ov_w0}, {7'b0, a1.ev});
        end
        if (a2_ok) begin
            check("p1 out",   {7'b0, o_p1},  {7'b0, a2.e1});
            check("p1 valid", {7'b0, ov_p1}, {7'b0, a2.ev});
            check("w1 out",   o_w1,          a2.e8);
            check("w1 valid", {7'b0, ov_w1}, {7'b0, a2.ev});
        end
        a2       = a1;
        a2_ok    = a1_ok;
        a1.e1    = v_e1;
        a1.e8    = v_e8;
        a1.ev    = v_vld;
        a1_ok    = chk;
        in1      = v_in;
        sel      = v_sel;
        in_valid = v_vld;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [12];
        tbl[0]  = '{16'h0000, 4'h0, 1'b1, 1'b0, 8'h10};
        tbl[1]  = '{16'h3f0a, 4'h0, 1'b1, 1'b0, 8'h10};
        tbl[2]  = '{16'h3f0a, 4'h1, 1'b1, 1'b1, 8'h11};
        tbl[3]  = '{16'h3f0a, 4'h6, 1'b1, 1'b0, 8'h16};
        tbl[4]  = '{16'h3f0a, 4'hc, 1'b1, 1'b1, 8'h1c};
        tbl[5]  = '{16'hffff, 4'h3, 1'b0, 1'b1, 8'h1c};
        tbl[6]  = '{16'h0000, 4'h5, 1'b0, 1'b1, 8'h1c};
        tbl[7]  = '{16'hc0f5, 4'h9, 1'b0, 1'b1, 8'h1c};
        tbl[8]  = '{16'h3f0a, 4'h3, 1'b1, 1'b1, 8'h13};
        tbl[9]  = '{16'h3f0a, 4'h9, 1'b1, 1'b1, 8'h19};
        tbl[10] = '{16'h3f0a, 4'hf, 1'b1, 1'b0, 8'h1f};
        tbl[11] = '{16'h3f0a, 4'hd, 1'b1, 1'b1, 8'h1d};

        for (int k = 0; k < 16; k++) begin
            in8[k*8 +: 8] = 8'h10 + 8'(k);
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        sel      = 4'h0;
        in1      = 16'h0000;

        #3;
        check_all_zero("reset");
        @(negedge clk);
        check_all_zero("reset held");
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].in1, tbl[i].sel, tbl[i].vld, tbl[i].e1, tbl[i].e8, 1'b1);
        end

        for (int k = 0; k < 16; k++) begin
            for (int s = 0; s < 16; s++) begin
                logic [15:0] w;
                w = 16'h0001 << k;
                step(w, 4'(s), 1'b1, (s == k), 8'h10 + 8'(s), 1'b1);
            end
        end
        for (int k = 0; k < 16; k++) begin
            for (int s = 0; s < 16; s++) begin
                logic [15:0] w;
                w = ~(16'h0001 << k);
                step(w, 4'(s), 1'b1, (s != k), 8'h10 + 8'(s), 1'b1);
            end
        end

        for (int s = 15; s >= 0; s--) begin
            logic [15:0] w;
            w = 16'h3f0a;
            step(w, 4'(s), 1'b1, w[s], 8'h10 + 8'(s), 1'b1);
        end

        // Assert reset while a stream is in flight, then hold the outputs idle after release.
        step(16'h3f0a, 4'hc, 1'b1, 1'b1, 8'h1c, 1'b1);
        step(16'h3f0a, 4'hc, 1'b1, 1'b1, 8'h1c, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async reset");
        a1_ok = 1'b0;
        a2_ok = 1'b0;
        @(negedge clk);
        check_all_zero("reset mid");
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_all_zero("post reset idle");

        step(16'h3f0a, 4'hc, 1'b1, 1'b1, 8'h1c, 1'b1);
        step(16'h3f0a, 4'h6, 1'b1, 1'b0, 8'h16, 1'b1);
        step(16'h0000, 4'h0, 1'b0, 1'b0, 8'h16, 1'b1);
        step(16'h0000, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(16'h0000, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
